// File: rtl/detector_pkg.sv
// rtl/detector_pkg.sv - shared state encoding and width helper for the first-arrival detector
package detector_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    COLLECT = 2'd1,
    LOCKED  = 2'd2
  } det_state_e;

  // Index width that never collapses to zero bits for tiny channel counts.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - combinational lowest-set-bit encoder
module prio_enc_lsb
  import detector_pkg::*;
#(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0]              vec,
  output logic [idx_width(N_CH)-1:0]   first_idx,
  output logic                         found
);

  localparam int IDX_W = idx_width(N_CH);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    first_idx = '0;
    found     = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        first_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_first_detector.sv
// rtl/multi_first_detector.sv - N-channel first-arrival detector with coincidence window and timestamp
module multi_first_detector
  import detector_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int TS_W      = 16,
  parameter int WINDOW    = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            sig,
  input  logic                       ack,
  output logic [N_CH-1:0]            y,
  output logic [idx_width(N_CH)-1:0] first_idx,
  output logic [TS_W-1:0]            ts,
  output logic                       valid,
  output logic                       armed
);

  localparam int IDX_W = idx_width(N_CH);
  localparam int WIN_W = idx_width(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(WINDOW);
  localparam logic [TS_W-1:0]  TS_MAX   = '1;

  det_state_e       state_q, state_d;
  logic [N_CH-1:0]  sig_q;
  logic [N_CH-1:0]  det;
  logic [N_CH-1:0]  y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] enc_idx;
  logic             det_any;

  assign det = (EDGE_MODE != 0) ? (sig & ~sig_q) : sig;

  prio_enc_lsb #(
    .N_CH (N_CH)
  ) u_prio_enc (
    .vec       (det),
    .first_idx (enc_idx),
    .found     (det_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARMED;
      sig_q    <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      ts_q     <= '0;
      ts_cnt_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig;
      y_q      <= y_d;
      idx_q    <= idx_d;
      ts_q     <= ts_d;
      ts_cnt_q <= ts_cnt_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    idx_d    = idx_q;
    ts_d     = ts_q;
    ts_cnt_d = ts_cnt_q;
    win_d    = win_q;
    unique case (state_q)
      ARMED: begin
        if (ts_cnt_q != TS_MAX) ts_cnt_d = ts_cnt_q + 1'b1;
        if (det_any) begin
          y_d   = det;
          idx_d = enc_idx;
          ts_d  = ts_cnt_q;
          if (WINDOW == 0) begin
            state_d = LOCKED;
          end else begin
            state_d = COLLECT;
            win_d   = WIN_INIT;
          end
        end
      end
      COLLECT: begin
        // The cycle with win_cnt at 1 still merges before locking.
        y_d   = y_q | det;
        win_d = win_q - 1'b1;
        if (win_q <= WIN_W'(1)) state_d = LOCKED;
      end
      LOCKED: begin
        if (ack) begin
          state_d  = ARMED;
          y_d      = '0;
          idx_d    = '0;
          ts_d     = '0;
          ts_cnt_d = '0;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  assign y         = y_q;
  assign first_idx = idx_q;
  assign ts        = ts_q;
  assign valid     = (state_q == LOCKED);
  assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_multi_first_detector.sv
// tb/tb_multi_first_detector.sv - directed self-checking bench for multi_first_detector
module tb_multi_first_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Level mode, no window
  logic rst_l, ack_l, valid_l, armed_l;
  logic [7:0] sig_l, y_l;
  logic [2:0] idx_l;
  logic [15:0] ts_l;
  // Level mode, window of 2
  logic rst_w, ack_w, valid_w, armed_w;
  logic [7:0] sig_w, y_w;
  logic [2:0] idx_w;
  logic [15:0] ts_w;
  // Edge mode
  logic rst_e, ack_e, valid_e, armed_e;
  logic [7:0] sig_e, y_e;
  logic [2:0] idx_e;
  logic [15:0] ts_e;
  // 4-bit timestamp
  logic rst_s, ack_s, valid_s, armed_s;
  logic [7:0] sig_s, y_s;
  logic [2:0] idx_s;
  logic [3:0] ts_s;

  multi_first_detector #(.N_CH(8), .TS_W(16), .WINDOW(0), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst_l), .sig(sig_l), .ack(ack_l), .y(y_l),
    .first_idx(idx_l), .ts(ts_l), .valid(valid_l), .armed(armed_l));

  multi_first_detector #(.N_CH(8), .TS_W(16), .WINDOW(2), .EDGE_MODE(0)) u_win (
    .clk(clk), .rst(rst_w), .sig(sig_w), .ack(ack_w), .y(y_w),
    .first_idx(idx_w), .ts(ts_w), .valid(valid_w), .armed(armed_w));

  multi_first_detector #(.N_CH(8), .TS_W(16), .WINDOW(0), .EDGE_MODE(1)) u_edge (
    .clk(clk), .rst(rst_e), .sig(sig_e), .ack(ack_e), .y(y_e),
    .first_idx(idx_e), .ts(ts_e), .valid(valid_e), .armed(armed_e));

  multi_first_detector #(.N_CH(8), .TS_W(4), .WINDOW(0), .EDGE_MODE(0)) u_sat (
    .clk(clk), .rst(rst_s), .sig(sig_s), .ack(ack_s), .y(y_s),
    .first_idx(idx_s), .ts(ts_s), .valid(valid_s), .armed(armed_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_l = 1'b0; rst_w = 1'b0; rst_e = 1'b0; rst_s = 1'b0;
    ack_l = 1'b0; ack_w = 1'b0; ack_e = 1'b0; ack_s = 1'b0;
    sig_l = '0; sig_w = '0; sig_e = '0; sig_s = '0;
    tick();
    tick();
    rst_l = 1'b1; rst_w = 1'b1; rst_e = 1'b1; rst_s = 1'b1;

    // 1. reset state, then three idle cycles
    check("rst_y", y_l, 8'h00);
    check("rst_valid", valid_l, 1'b0);
    check("rst_armed", armed_l, 1'b1);
    check("rst_ts", ts_l, 16'h0);
    check("rst_idx", idx_l, 3'd0);
    check("rst_win_armed", armed_w, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_y", y_l, 8'h00);
      check("idle_valid", valid_l, 1'b0);
      check("idle_armed", armed_l, 1'b1);
    end

    // 2. single winner on the 5th armed cycle
    tick();
    sig_l = 8'h10;
    tick();
    check("single_y", y_l, 8'h10);
    check("single_idx", idx_l, 3'd4);
    check("single_ts", ts_l, 16'd4);
    check("single_valid", valid_l, 1'b1);
    check("single_armed", armed_l, 1'b0);
    sig_l = 8'hFF;
    tick();
    check("locked_ff_y", y_l, 8'h10);
    sig_l = 8'h00;
    tick();
    check("locked_y", y_l, 8'h10);
    check("locked_ts", ts_l, 16'd4);
    check("locked_valid", valid_l, 1'b1);
    ack_l = 1'b1;
    tick();
    ack_l = 1'b0;
    check("ack1_valid", valid_l, 1'b0);
    check("ack1_armed", armed_l, 1'b1);
    check("ack1_y", y_l, 8'h00);
    check("ack1_ts", ts_l, 16'h0);

    // 3. simultaneous arrivals on the first armed cycle
    sig_l = 8'h81;
    tick();
    sig_l = 8'h00;
    check("simul_y", y_l, 8'h81);
    check("simul_idx", idx_l, 3'd0);
    check("simul_ts", ts_l, 16'd0);
    check("simul_valid", valid_l, 1'b1);
    ack_l = 1'b1;
    tick();
    ack_l = 1'b0;
    check("ack2_y", y_l, 8'h00);
    check("ack2_valid", valid_l, 1'b0);
    check("ack2_armed", armed_l, 1'b1);

    // level mode: channel held high across ack is seen at ts 0
    sig_l = 8'h40;
    tick();
    check("lvl_pre_y", y_l, 8'h40);
    ack_l = 1'b1;
    tick();
    ack_l = 1'b0;
    check("lvl_ack_armed", armed_l, 1'b1);
    tick();
    sig_l = 8'h00;
    check("lvl_rehold_y", y_l, 8'h40);
    check("lvl_rehold_ts", ts_l, 16'd0);
    check("lvl_rehold_idx", idx_l, 3'd6);
    check("lvl_rehold_valid", valid_l, 1'b1);

    // 4. coincidence window of 2
    sig_w = 8'h04;
    tick();
    check("win_k_y", y_w, 8'h04);
    check("win_k_idx", idx_w, 3'd2);
    check("win_k_valid", valid_w, 1'b0);
    check("win_k_armed", armed_w, 1'b0);
    sig_w = 8'h00;
    tick();
    check("win_k1_valid", valid_w, 1'b0);
    sig_w = 8'h02;
    tick();
    check("win_k2_y", y_w, 8'h06);
    check("win_k2_valid", valid_w, 1'b1);
    sig_w = 8'h01;
    tick();
    sig_w = 8'h00;
    check("win_k3_y", y_w, 8'h06);
    check("win_k3_idx", idx_w, 3'd2);
    check("win_k3_valid", valid_w, 1'b1);
    ack_w = 1'b1;
    tick();
    ack_w = 1'b0;
    check("win_ack_armed", armed_w, 1'b1);
    // reset in the middle of collecting
    sig_w = 8'h20;
    tick();
    sig_w = 8'h00;
    check("win_mid_y", y_w, 8'h20);
    check("win_mid_armed", armed_w, 1'b0);
    rst_w = 1'b0;
    tick();
    rst_w = 1'b1;
    check("win_rst_y", y_w, 8'h00);
    check("win_rst_valid", valid_w, 1'b0);
    check("win_rst_armed", armed_w, 1'b1);
    tick();
    tick();
    check("win_rst_stay_valid", valid_w, 1'b0);
    check("win_rst_stay_armed", armed_w, 1'b1);

    // 5. edge mode: held channel does not retrigger
    sig_e = 8'h08;
    tick();
    check("edge_first_y", y_e, 8'h08);
    check("edge_first_idx", idx_e, 3'd3);
    check("edge_first_valid", valid_e, 1'b1);
    ack_e = 1'b1;
    tick();
    ack_e = 1'b0;
    check("edge_ack_armed", armed_e, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("edge_hold_armed", armed_e, 1'b1);
      check("edge_hold_y", y_e, 8'h00);
    end
    sig_e = 8'h00;
    tick();
    check("edge_low_armed", armed_e, 1'b1);
    sig_e = 8'h08;
    tick();
    check("edge_rise_y", y_e, 8'h08);
    check("edge_rise_valid", valid_e, 1'b1);
    check("edge_rise_ts", ts_e, 16'd4);

    // 6. timestamp saturation with a 4-bit counter
    ack_s = 1'b0;
    rst_s = 1'b0;
    tick();
    rst_s = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_armed", armed_s, 1'b1);
    sig_s = 8'h01;
    tick();
    sig_s = 8'h00;
    check("sat_ts", ts_s, 4'hF);
    check("sat_idx", idx_s, 3'd0);
    check("sat_y", y_s, 8'h01);
    ack_s = 1'b1;
    tick();
    ack_s = 1'b0;
    tick();
    tick();
    sig_s = 8'h80;
    tick();
    sig_s = 8'h00;
    check("sat_rearm_ts", ts_s, 4'd2);
    check("sat_rearm_idx", idx_s, 3'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
